// File: rtl/port_rst_ctrl_pkg.sv
// Shared types and default timing for the per-port soft-reset drain sequencer.
package port_rst_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        ASSERT = 2'd2
    } t_rst_state;

    localparam int DEF_RST_HOLD_CYCLES = 16;
    localparam int DEF_DRAIN_TIMEOUT   = 1024;

endpackage

// File: rtl/port_rst_drain_ch.sv
// One port's soft-reset channel: blocks TX-A, waits for the open packet to close
// (or times out), then holds the port reset low for a minimum time.
module port_rst_drain_ch
    import port_rst_ctrl_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
    parameter int DRAIN_TIMEOUT   = DEF_DRAIN_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic soft_rst_req,
    input  logic tx_tvalid,
    input  logic tx_tready,
    input  logic tx_tlast,
    input  logic timeout_clr,
    output logic tx_block,
    output logic port_rst_n,
    output logic rst_busy,
    output logic drain_timeout
);

    localparam int HW = $clog2(RST_HOLD_CYCLES) + 1;
    localparam int TW = $clog2(DRAIN_TIMEOUT) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(DRAIN_TIMEOUT - 1);

    t_rst_state    state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          in_pkt_q, in_pkt_d;
    logic          port_rst_n_q, port_rst_n_d;
    logic          tx_block_q, tx_block_d;
    logic          rst_busy_q, rst_busy_d;
    logic          drain_timeout_q, drain_timeout_d;
    logic          beat, in_pkt_nx, tmo_set;

    always_comb begin
        beat       = tx_tvalid & tx_tready;
        in_pkt_nx  = beat ? ~tx_tlast : in_pkt_q;
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        in_pkt_d   = in_pkt_nx;
        tmo_set    = 1'b0;
        case (state_q)
            RUN: begin
                if (soft_rst_req) begin
                    state_d   = DRAIN;
                    tmo_cnt_d = '0;
                end
            end
            DRAIN: begin
                // Drained means the packet is closed after this cycle's beat.
                if (!in_pkt_nx) begin
                    state_d    = ASSERT;
                    hold_cnt_d = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d    = ASSERT;
                    hold_cnt_d = '0;
                    tmo_set    = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ASSERT: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    if (!soft_rst_req) state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = ASSERT;
        endcase
        if (state_q == ASSERT || state_d == ASSERT) in_pkt_d = 1'b0;
        port_rst_n_d    = (state_d != ASSERT);
        tx_block_d      = (state_d != RUN);
        rst_busy_d      = (state_d != RUN);
        drain_timeout_d = tmo_set ? 1'b1 : (timeout_clr ? 1'b0 : drain_timeout_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ASSERT;
            hold_cnt_q      <= '0;
            tmo_cnt_q       <= '0;
            in_pkt_q        <= 1'b0;
            port_rst_n_q    <= 1'b0;
            tx_block_q      <= 1'b1;
            rst_busy_q      <= 1'b1;
            drain_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            tmo_cnt_q       <= tmo_cnt_d;
            in_pkt_q        <= in_pkt_d;
            port_rst_n_q    <= port_rst_n_d;
            tx_block_q      <= tx_block_d;
            rst_busy_q      <= rst_busy_d;
            drain_timeout_q <= drain_timeout_d;
        end
    end

    assign tx_block      = tx_block_q;
    assign port_rst_n    = port_rst_n_q;
    assign rst_busy      = rst_busy_q;
    assign drain_timeout = drain_timeout_q;

endmodule

// File: rtl/port_rst_drain_ctrl.sv
// Soft-reset sequencer for all AFU ports: one fully independent drain channel per port.
module port_rst_drain_ctrl
    import port_rst_ctrl_pkg::*;
#(
    parameter int PG_NUM_PORTS    = 1,
    parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
    parameter int DRAIN_TIMEOUT   = DEF_DRAIN_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PG_NUM_PORTS-1:0] i_soft_rst_req,
    input  logic [PG_NUM_PORTS-1:0] i_tx_tvalid,
    input  logic [PG_NUM_PORTS-1:0] i_tx_tready,
    input  logic [PG_NUM_PORTS-1:0] i_tx_tlast,
    input  logic [PG_NUM_PORTS-1:0] i_timeout_clr,
    output logic [PG_NUM_PORTS-1:0] o_tx_block,
    output logic [PG_NUM_PORTS-1:0] o_port_rst_n,
    output logic [PG_NUM_PORTS-1:0] o_rst_busy,
    output logic [PG_NUM_PORTS-1:0] o_drain_timeout
);

    for (genvar i = 0; i < PG_NUM_PORTS; i++) begin : g_ch
        port_rst_drain_ch #(
            .RST_HOLD_CYCLES(RST_HOLD_CYCLES),
            .DRAIN_TIMEOUT  (DRAIN_TIMEOUT)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .soft_rst_req (i_soft_rst_req[i]),
            .tx_tvalid    (i_tx_tvalid[i]),
            .tx_tready    (i_tx_tready[i]),
            .tx_tlast     (i_tx_tlast[i]),
            .timeout_clr  (i_timeout_clr[i]),
            .tx_block     (o_tx_block[i]),
            .port_rst_n   (o_port_rst_n[i]),
            .rst_busy     (o_rst_busy[i]),
            .drain_timeout(o_drain_timeout[i])
        );
    end

endmodule

// File: tb/tb_port_rst_drain_ctrl.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a negedge monitor compares them.
module tb_port_rst_drain_ctrl;

    localparam int NP = 3;
    // expected value packing: {port_rst_n, tx_block, rst_busy, drain_timeout}
    localparam logic [3:0] RUNV  = 4'b1000;
    localparam logic [3:0] DRV   = 4'b1110;
    localparam logic [3:0] ASV   = 4'b0110;
    localparam logic [3:0] ASVT  = 4'b0111;
    localparam logic [3:0] RUNVT = 4'b1001;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NP-1:0] req, tvalid, tready, tlast, tclr;
    logic [NP-1:0] blk, prst_n, busy, tmo;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        int         p;
        logic [3:0] v;
        int         tid;
    } exp_t;
    exp_t sb[$];

    port_rst_drain_ctrl #(
        .PG_NUM_PORTS   (NP),
        .RST_HOLD_CYCLES(16),
        .DRAIN_TIMEOUT  (1024)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_soft_rst_req (req),
        .i_tx_tvalid    (tvalid),
        .i_tx_tready    (tready),
        .i_tx_tlast     (tlast),
        .i_timeout_clr  (tclr),
        .o_tx_block     (blk),
        .o_port_rst_n   (prst_n),
        .o_rst_busy     (busy),
        .o_drain_timeout(tmo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [3:0] act;
                act = {prst_n[sb[i].p], blk[sb[i].p], busy[sb[i].p], tmo[sb[i].p]};
                checks++;
                if (act !== sb[i].v) begin
                    errors++;
                    $display("FAIL t%0d_outs cyc=%0d port=%0d got=%b exp=%b (rst_n,block,busy,tmo)",
                             sb[i].tid, cyc, sb[i].p, act, sb[i].v);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                errors++;
                $display("FAIL t%0d_stale cyc=%0d port=%0d got=unchecked exp=%b",
                         sb[i].tid, sb[i].cyc, sb[i].p, sb[i].v);
                sb.delete(i);
            end
        end
    end

    task automatic ex(input int c0, input int c1, input int p, input logic [3:0] v, input int tid);
        for (int c = c0; c <= c1; c++) begin
            exp_t e;
            e.cyc = c; e.p = p; e.v = v; e.tid = tid;
            sb.push_back(e);
        end
    endtask

    task automatic ex_all(input int c0, input int c1, input logic [3:0] v, input int tid);
        for (int p = 0; p < NP; p++) ex(c0, c1, p, v, tid);
    endtask

    task automatic ex_oth(input int c0, input int c1, input int tid);
        ex(c0, c1, 0, RUNV, tid);
        ex(c0, c1, 2, RUNV, tid);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int b;
        rst_n = 1'b0; req = '0; tvalid = '0; tready = '0; tlast = '0; tclr = '0;

        // 1: reset values, then exactly 16 cycles of port reset after release
        tick(2);
        ex_all(2, 2, ASV, 1);
        tick(1);
        rst_n = 1'b1;
        ex_all(3, 18, ASV, 1);
        ex_all(19, 19, RUNV, 1);
        tick(20);

        // 2: idle port, one-cycle request
        b = cyc;
        req[1] = 1'b1;
        ex(b, b, 1, RUNV, 2);
        ex(b + 1, b + 1, 1, DRV, 2);
        ex(b + 2, b + 17, 1, ASV, 2);
        ex(b + 18, b + 18, 1, RUNV, 2);
        ex_oth(b, b + 18, 2);
        tick(1);
        req[1] = 1'b0;
        tick(21);

        // 3: 4-beat packet, request on beat 2 and dropped during DRAIN
        b = cyc;
        tvalid[1] = 1'b1; tready[1] = 1'b1; tlast[1] = 1'b0;
        ex(b + 1, b + 1, 1, RUNV, 3);
        ex(b + 2, b + 3, 1, DRV, 3);
        ex(b + 4, b + 19, 1, ASV, 3);
        ex(b + 20, b + 20, 1, RUNV, 3);
        ex_oth(b, b + 20, 3);
        tick(1);
        req[1] = 1'b1;
        tick(1);
        req[1] = 1'b0;
        tick(1);
        tlast[1] = 1'b1;
        tick(1);
        tvalid[1] = 1'b0; tlast[1] = 1'b0;
        tick(20);

        // 5: request held 40 cycles; a beat inside ASSERT must not open a packet
        b = cyc;
        req[1] = 1'b1;
        ex(b + 1, b + 1, 1, DRV, 5);
        ex(b + 2, b + 40, 1, ASV, 5);
        ex(b + 41, b + 45, 1, RUNV, 5);
        ex(b + 46, b + 46, 1, DRV, 5);
        ex(b + 47, b + 62, 1, ASV, 5);
        ex(b + 63, b + 63, 1, RUNV, 5);
        ex_oth(b, b + 63, 5);
        tick(10);
        tvalid[1] = 1'b1; tready[1] = 1'b1; tlast[1] = 1'b0;
        tick(1);
        tvalid[1] = 1'b0;
        tick(29);
        req[1] = 1'b0;
        tick(5);
        req[1] = 1'b1;
        tick(1);
        req[1] = 1'b0;
        tick(20);

        // 4: stalled packet -> forced at DRAIN cycle 1024; clear coincident with set loses
        b = cyc;
        tvalid[1] = 1'b1; tready[1] = 1'b1; tlast[1] = 1'b0;
        ex(b + 1, b + 1, 1, RUNV, 4);
        ex(b + 2, b + 2, 1, DRV, 4);
        ex(b + 500, b + 500, 1, DRV, 4);
        ex(b + 1025, b + 1025, 1, DRV, 4);
        ex(b + 1026, b + 1041, 1, ASVT, 4);
        ex(b + 1042, b + 1046, 1, RUNVT, 4);
        ex(b + 1047, b + 1048, 1, RUNV, 4);
        ex_oth(b, b + 2, 4);
        ex_oth(b + 1024, b + 1048, 4);
        tick(1);
        tready[1] = 1'b0; req[1] = 1'b1;
        tick(1);
        req[1] = 1'b0;
        tick(1023);
        tclr[1] = 1'b1;
        tick(1);
        tclr[1] = 1'b0; tvalid[1] = 1'b0;
        tick(20);
        tclr[1] = 1'b1;
        tick(1);
        tclr[1] = 1'b0;
        tick(4);

        // 6: global reset mid-DRAIN forces every port into ASSERT, packet state cleared
        b = cyc;
        tvalid[1] = 1'b1; tready[1] = 1'b1; tlast[1] = 1'b0;
        ex(b + 2, b + 4, 1, DRV, 6);
        ex_oth(b, b + 4, 6);
        ex_all(b + 5, b + 22, ASV, 6);
        ex_all(b + 23, b + 25, RUNV, 6);
        ex(b + 26, b + 26, 1, DRV, 6);
        ex(b + 27, b + 27, 1, ASV, 6);
        ex_oth(b + 23, b + 27, 6);
        tick(1);
        tready[1] = 1'b0; req[1] = 1'b1;
        tick(1);
        req[1] = 1'b0;
        tick(3);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1; tvalid[1] = 1'b0;
        tick(18);
        req[1] = 1'b1;
        tick(1);
        req[1] = 1'b0;
        tick(5);

        if (sb.size() != 0) begin
            $display("FAIL sb_leftover got=%0d pending exp=0", sb.size());
            errors += sb.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
